pattern_scheduler: RTL and testbench

PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

---
 rtl/pattern_scheduler.sv | 151 +++++++++++++++
 tb/tb_pattern_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scheduler
// Description : Two-requester round-robin scheduler. The winner's selected
//               pattern (alternating 1010... or its inverse) is latched and
//               shifted out serially, LSB first. The transfer ends with a
//               one-cycle done pulse and one mandatory IDLE cycle.
// Ports       : clk         - rising-edge clock
//               rst         - synchronous active-high reset
//               req[1:0]    - per-requester transfer request
//               sel[1:0]    - per-requester select (1: pattern_1, 0: pattern_0)
//               gnt[1:0]    - one-hot grant, held for the whole transfer
//               busy        - high while in SHIFT or DONE
//               pattern_out - pattern latched for the current transfer
//               ser_out     - serial pattern bit
//               ser_valid   - qualifier for ser_out
//               bit_idx     - index of the bit currently on ser_out
//               done        - one-cycle end-of-transfer pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_scheduler #(
    parameter int WIDTH = 127,
    parameter int CNT_W = 7      // must be at least clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       sel,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] pattern_out,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [CNT_W-1:0] bit_idx,
    output logic             done
);

    localparam logic [1:0]       c_st_idle  = 2'd0;
    localparam logic [1:0]       c_st_shift = 2'd1;
    localparam logic [1:0]       c_st_done  = 2'd2;
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_gnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_pattern;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic [CNT_W-1:0] r_bit_idx;
    logic             r_done;
    logic             r_last;       // requester served by the last completed transfer

    logic [WIDTH-1:0] w_pattern_1;
    logic [WIDTH-1:0] w_pattern_0;
    logic             w_winner;
    logic             w_win_sel;
    logic [WIDTH-1:0] w_load_pattern;
    logic [CNT_W-1:0] w_next_idx;

    // pattern_1 has ones on even bit positions
    for (genvar i = 0; i < WIDTH; i++) begin : g_pattern
        assign w_pattern_1[i] = ((i % 2) == 0) ? 1'b1 : 1'b0;
    end

    assign w_pattern_0 = ~w_pattern_1;

    // Under contention the requester not served last wins; a lone request
    // always wins regardless of the pointer.
    always_comb begin
        w_winner = 1'b0;
        if (req == 2'b11) begin
            w_winner = ~r_last;
        end else begin
            w_winner = req[1];
        end
    end

    assign w_win_sel      = w_winner ? sel[1] : sel[0];
    assign w_load_pattern = w_win_sel ? w_pattern_1 : w_pattern_0;
    assign w_next_idx     = r_bit_idx + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_gnt       <= 2'b00;
            r_busy      <= 1'b0;
            r_pattern   <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_bit_idx   <= '0;
            r_done      <= 1'b0;
            r_last      <= 1'b1;        // requester 0 wins first contention
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req != 2'b00) begin
                        r_state     <= c_st_shift;
                        r_gnt       <= w_winner ? 2'b10 : 2'b01;
                        r_busy      <= 1'b1;
                        r_pattern   <= w_load_pattern;
                        r_bit_idx   <= '0;
                        // bit 0 is presented on the grant edge itself
                        r_ser_out   <= w_load_pattern[0];
                        r_ser_valid <= 1'b1;
                    end
                end
                c_st_shift: begin
                    if (r_bit_idx == c_last_idx) begin
                        // bit_idx is frozen at its last value until IDLE
                        r_state     <= c_st_done;
                        r_ser_out   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_bit_idx   <= w_next_idx;
                        r_ser_out   <= r_pattern[w_next_idx];
                    end
                end
                c_st_done: begin
                    r_state   <= c_st_idle;
                    r_gnt     <= 2'b00;
                    r_busy    <= 1'b0;
                    r_pattern <= '0;
                    r_bit_idx <= '0;
                    r_done    <= 1'b0;
                    r_last    <= r_gnt[1];
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_gnt       <= 2'b00;
                    r_busy      <= 1'b0;
                    r_pattern   <= '0;
                    r_ser_out   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_bit_idx   <= '0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign pattern_out = r_pattern;
    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign bit_idx     = r_bit_idx;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_scheduler
// Description : Directed self-checking bench for pattern_scheduler.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_scheduler;

    logic         clk;
    logic         rst;
    logic [1:0]   req;
    logic [1:0]   sel;
    logic [1:0]   gnt;
    logic         busy;
    logic [126:0] pattern_out;
    logic         ser_out;
    logic         ser_valid;
    logic [6:0]   bit_idx;
    logic         done;

    logic [126:0] exp_p1;
    logic [126:0] exp_p0;
    logic         seen_127;
    int           n_tests;
    int           n_fail;

    pattern_scheduler #(
        .WIDTH (127),
        .CNT_W (7)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .sel         (sel),
        .gnt         (gnt),
        .busy        (busy),
        .pattern_out (pattern_out),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .bit_idx     (bit_idx),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial seen_127 = 1'b0;
    always @(negedge clk) begin
        if (bit_idx == 7'd127) seen_127 = 1'b1;
    end

    task automatic test_reset;
        rst = 1'b1; req = 2'b00; sel = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({gnt, busy, pattern_out, ser_out, ser_valid, bit_idx, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b busy=%b ser_valid=%b bit_idx=%0d done=%b pattern_nonzero=%b want all 0",
                     gnt, busy, ser_valid, bit_idx, done, |pattern_out);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b gnt=%b want 0/00", busy, gnt);
        end
    endtask

    task automatic test_single;
        int err;
        req = 2'b01; sel = 2'b01;
        @(negedge clk);
        req = 2'b00; sel = 2'b00;
        n_tests++;
        if (gnt !== 2'b01 || pattern_out !== exp_p1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b busy=%b pat_ok=%b want 01/1/1", gnt, busy, pattern_out === exp_p1);
        end
        err = 0;
        for (int k = 0; k < 127; k++) begin
            if (ser_valid !== 1'b1 || bit_idx !== k[6:0] || ser_out !== exp_p1[k] || gnt !== 2'b01) err++;
            @(negedge clk);
        end
        n_tests++;
        if (err != 0) begin
            n_fail++;
            $display("FAIL single_stream: %0d bad cycles, want 0", err);
        end
        n_tests++;
        if (done !== 1'b1 || ser_valid !== 1'b0 || gnt !== 2'b01 || busy !== 1'b1 || bit_idx === 7'd127) begin
            n_fail++;
            $display("FAIL single_done: done=%b ser_valid=%b gnt=%b busy=%b bit_idx=%0d want 1/0/01/1/!=127",
                     done, ser_valid, gnt, busy, bit_idx);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || gnt !== 2'b00 || pattern_out !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: done=%b gnt=%b busy=%b want 0/00/0", done, gnt, busy);
        end
    endtask

    task automatic test_contention;
        int           err;
        logic [1:0]   eg;
        logic [126:0] ep;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 2'b11; sel = 2'b01;
        @(negedge clk);
        for (int t = 0; t < 3; t++) begin
            eg = (t % 2 == 0) ? 2'b01 : 2'b10;
            ep = (t % 2 == 0) ? exp_p1 : exp_p0;
            n_tests++;
            if (gnt !== eg || pattern_out !== ep) begin
                n_fail++;
                $display("FAIL contention_grant%0d: gnt=%b want %b pat_ok=%b", t, gnt, eg, pattern_out === ep);
            end
            err = 0;
            for (int k = 0; k < 127; k++) begin
                if (ser_valid !== 1'b1 || bit_idx !== k[6:0] || ser_out !== ep[k] || gnt !== eg) err++;
                @(negedge clk);
            end
            n_tests++;
            if (err != 0 || done !== 1'b1 || gnt !== eg) begin
                n_fail++;
                $display("FAIL contention_xfer%0d: bad=%0d done=%b gnt=%b want 0/1/%b", t, err, done, gnt, eg);
            end
            @(negedge clk);
            n_tests++;
            if (gnt !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_gap%0d: gnt=%b busy=%b done=%b want 00/0/0", t, gnt, busy, done);
            end
            @(negedge clk);
        end
        n_tests++;
        if (gnt !== 2'b10 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL contention_fourth: gnt=%b busy=%b want 10/1", gnt, busy);
        end
        req = 2'b00; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pattern_sel;
        int err;
        req = 2'b10; sel = 2'b00;
        @(negedge clk);
        req = 2'b00;
        n_tests++;
        if (gnt !== 2'b10 || pattern_out !== exp_p0) begin
            n_fail++;
            $display("FAIL sel_grant: gnt=%b want 10 pat_ok=%b", gnt, pattern_out === exp_p0);
        end
        err = 0;
        for (int k = 0; k < 127; k++) begin
            if (ser_valid !== 1'b1 || bit_idx !== k[6:0] || ser_out !== exp_p0[k]) err++;
            @(negedge clk);
        end
        n_tests++;
        if (err != 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_stream: bad=%0d done=%b want 0/1", err, done);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_change;
        int err;
        req = 2'b01; sel = 2'b01;
        @(negedge clk);
        err = 0;
        for (int k = 0; k < 127; k++) begin
            if (ser_valid !== 1'b1 || bit_idx !== k[6:0] || ser_out !== exp_p1[k] ||
                pattern_out !== exp_p1 || gnt !== 2'b01 || done !== 1'b0) err++;
            if (k == 50) begin
                sel = 2'b10; req = 2'b00;
            end
            @(negedge clk);
        end
        n_tests++;
        if (err != 0) begin
            n_fail++;
            $display("FAIL mid_change_stream: %0d bad cycles, want 0", err);
        end
        n_tests++;
        if (done !== 1'b1 || gnt !== 2'b01 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_change_done: done=%b gnt=%b busy=%b want 1/01/1", done, gnt, busy);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_change_noqueue: busy=%b gnt=%b want 0/00", busy, gnt);
        end
    endtask

    task automatic test_reset_mid;
        int err;
        req = 2'b10; sel = 2'b10;
        @(negedge clk);
        req = 2'b00;
        err = 0;
        for (int k = 0; k <= 60; k++) begin
            if (ser_valid !== 1'b1 || bit_idx !== k[6:0] || ser_out !== exp_p1[k] || gnt !== 2'b10) err++;
            if (k < 60) @(negedge clk);
        end
        n_tests++;
        if (err != 0) begin
            n_fail++;
            $display("FAIL reset_mid_stream: %0d bad cycles, want 0", err);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({gnt, busy, pattern_out, ser_out, ser_valid, bit_idx, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: gnt=%b busy=%b ser_valid=%b bit_idx=%0d done=%b want all 0",
                     gnt, busy, ser_valid, bit_idx, done);
        end
        rst = 1'b0; req = 2'b11; sel = 2'b00;
        @(negedge clk);
        n_tests++;
        if (gnt !== 2'b01 || pattern_out !== exp_p0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: gnt=%b done=%b want 01/0 pat_ok=%b", gnt, done, pattern_out === exp_p0);
        end
        req = 2'b00; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_boundary;
        n_tests++;
        if (seen_127 !== 1'b0) begin
            n_fail++;
            $display("FAIL bit_idx_range: saw bit_idx=127 (%b) want never", seen_127);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 127; i++) exp_p1[i] = (i % 2 == 0);
        exp_p0 = ~exp_p1;
        rst = 1'b1; req = 2'b00; sel = 2'b00;
        test_reset();
        test_single();
        test_contention();
        test_mid_change();
        test_pattern_sel();
        test_reset_mid();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
